// File: rtl/fp_add_arbiter.sv
// Round-robin wrapper that shares one combinational fp_adder among NUM_REQ requesters.
// Latency: a handshake in cycle t gives resp_valid in cycle t+2, and transactions are at least 3 cycles apart.
// Backpressure: with resp_ready low the result is held in RESP and no new grants are issued.
// Optional macro FP_ARB_SUB_EN adds a per-requester req_sub input; when set the adder computes A - B.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Truncating single-precision add: align, add or subtract, then normalise.
  // It has no rounding and no inf/nan/denormal handling.
  logic        a_big;
  logic [31:0] x, y;
  logic [7:0]  ex, ey, ediff, eres;
  logic [26:0] mx, my, my_sh;
  logic [27:0] mres, norm;
  logic [4:0]  lead, shift;

  always_comb begin
    a_big = (a[30:0] >= b[30:0]);
    x     = a_big ? a : b;
    y     = a_big ? b : a;
    ex    = x[30:23];
    ey    = y[30:23];
    mx    = {(ex != 8'd0), x[22:0], 3'b000};
    my    = {(ey != 8'd0), y[22:0], 3'b000};
    ediff = ex - ey;
    my_sh = (ediff > 8'd26) ? 27'd0 : (my >> ediff);
    if (x[31] == y[31]) mres = {1'b0, mx} + {1'b0, my_sh};
    else                mres = {1'b0, mx} - {1'b0, my_sh};
    lead = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (mres[i]) lead = 5'(i);
    end
    shift = 5'd26 - lead;
    if (mres[27]) begin
      norm = mres >> 1;
      eres = ex + 8'd1;
    end else begin
      norm = mres << shift;
      eres = ex - {3'b000, shift};
    end
    if (mres == 28'd0) sum = 32'd0;
    else               sum = {x[31], eres, 23'(norm >> 3)};
  end
endmodule

module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
`ifdef FP_ARB_SUB_EN
  input  logic [NUM_REQ-1:0]      req_sub,
`endif
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_sum,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     op_id;
  logic [31:0]         op_a, op_b, b_eff, sum;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [31:0]         sel_a, sel_b;
  logic [2*NUM_REQ-1:0] rot;
  int                  slot;
`ifdef FP_ARB_SUB_EN
  logic                op_sub;
  logic                sel_sub;
`endif

  // Rotating the doubled valid vector puts requester rr_ptr+1 at bit 0.
  always_comb begin
    rot       = {req_valid, req_valid} >> ({1'b0, rr_ptr} + 1'b1);
    grant_vld = 1'b0;
    grant_idx = '0;
    slot      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(rr_ptr) + 1 + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!grant_vld && rot[k]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(slot);
      end
    end
  end

  always_comb begin
    sel_a = 32'd0;
    sel_b = 32'd0;
`ifdef FP_ARB_SUB_EN
    sel_sub = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
`ifdef FP_ARB_SUB_EN
        sel_sub = req_sub[i];
`endif
      end
    end
  end

  // The grant is gated by rst so that req_ready reads 0 while reset is held.
  assign req_ready = (state == IDLE && !rst && grant_vld) ?
                     (NUM_REQ'(1) << grant_idx) : '0;

`ifdef FP_ARB_SUB_EN
  assign b_eff = {op_b[31] ^ op_sub, op_b[30:0]};
`else
  assign b_eff = op_b;
`endif

  fp_adder u_fp_adder (
    .a   (op_a),
    .b   (b_eff),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      op_id      <= '0;
`ifdef FP_ARB_SUB_EN
      op_sub     <= 1'b0;
`endif
      resp_valid <= 1'b0;
      resp_sum   <= 32'd0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_id  <= grant_idx;
`ifdef FP_ARB_SUB_EN
            op_sub <= sel_sub;
`endif
            rr_ptr <= grant_idx;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_sum   <= sum;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Define FP_ARB_SUB_EN to build the bench and the design with the subtract option.

module tb_fp_add_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a, req_b;
`ifdef FP_ARB_SUB_EN
  logic [N-1:0]    req_sub;
`endif
  logic            resp_valid, resp_ready;
  logic [31:0]     resp_sum;
  logic [1:0]      resp_id;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
`ifdef FP_ARB_SUB_EN
    .req_sub    (req_sub),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Exact IEEE single encoding of a small integer (|v| < 2^23).
  function automatic logic [31:0] to_float(input int v);
    logic [31:0] mag, f;
    int p;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) p = i;
    f = mag << (23 - p);
    return {(v < 0), 8'(127 + p), f[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
`ifdef FP_ARB_SUB_EN
    req_sub    = '0;
`endif
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Leaves the bench at the negedge where the awaited condition holds.
  task automatic wait_for(input bit want_resp, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (want_resp ? resp_valid : (req_ready != '0)) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    if (resp_sum !== 32'd0) begin n_bad++; $display("FAIL reset_resp_sum: got %h expected 0", resp_sum); end
    if (resp_id !== 2'd0) begin n_bad++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_cmp += 2;
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_no_valid_ready: got %b expected 0000", req_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    req_valid  = 4'b0001;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h3F800000;
    resp_ready = 1'b1;
    wait_for(1'b0, ok);
    n_cmp++;
    if (!ok || req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    req_a     = '1;
    @(negedge clk);
    n_cmp += 2;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_exec_valid: got %b expected 0", resp_valid); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_exec_busy: got %b expected 1", busy); end
    tick();
    @(negedge clk);
    n_cmp += 3;
    if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got %b expected 1", resp_valid); end
    if (resp_sum !== 32'h40000000) begin n_bad++; $display("FAIL single_sum: got %h expected 40000000", resp_sum); end
    if (resp_id !== 2'd0) begin n_bad++; $display("FAIL single_id: got %0d expected 0", resp_id); end
    tick();
    @(negedge clk);
    n_cmp += 2;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL single_release: got %b expected 0", resp_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_all_lanes();
    bit ok;
    logic [N-1:0] exp_g;
    apply_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3FC00000;
      req_b[32*i +: 32] = 32'h3FC00000;
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'(1) << (k % N);
      wait_for(1'b0, ok);
      n_cmp++;
      if (!ok || req_ready !== exp_g) begin n_bad++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_g); end
      tick();
      wait_for(1'b1, ok);
      n_cmp += 2;
      if (!ok || resp_sum !== 32'h40400000) begin n_bad++; $display("FAIL rr_sum_%0d: got %h expected 40400000", k, resp_sum); end
      if (!ok || resp_id !== 2'(k % N)) begin n_bad++; $display("FAIL rr_id_%0d: got %0d expected %0d", k, resp_id, k % N); end
      tick();
    end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3F800000;
    req_b[64 +: 32] = 32'h40000000;
    resp_ready = 1'b0;
    wait_for(1'b0, ok);
    n_cmp++;
    if (!ok || req_ready !== 4'b0100) begin n_bad++; $display("FAIL stall_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = 4'b1111;
    wait_for(1'b1, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL stall_resp_timeout: got %b expected 1", resp_valid); end
    for (int c = 0; c < 5; c++) begin
      n_cmp += 4;
      if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid_%0d: got %b expected 1", c, resp_valid); end
      if (resp_sum !== 32'h40400000) begin n_bad++; $display("FAIL stall_sum_%0d: got %h expected 40400000", c, resp_sum); end
      if (resp_id !== 2'd2) begin n_bad++; $display("FAIL stall_id_%0d: got %0d expected 2", c, resp_id); end
      if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready_%0d: got %b expected 0000", c, req_ready); end
      tick();
      @(negedge clk);
    end
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp += 2;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b expected 0", resp_valid); end
    if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL stall_next_grant: got %b expected 1000", req_ready); end
    tick();
  endtask

  task automatic test_reset_exec();
    bit ok;
    apply_reset();
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3F800000;
    req_b[64 +: 32] = 32'h3F800000;
    resp_ready = 1'b1;
    wait_for(1'b0, ok);
    n_cmp++;
    if (!ok || req_ready !== 4'b0100) begin n_bad++; $display("FAIL rstx_grant: got %b expected 0100", req_ready); end
    tick();
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_cmp += 3;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstx_valid: got %b expected 0", resp_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstx_busy: got %b expected 0", busy); end
    if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rstx_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rstx_next_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstx_exec_valid: got %b expected 0", resp_valid); end
    tick();
    @(negedge clk);
    n_cmp += 2;
    if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL rstx_resp_valid: got %b expected 1", resp_valid); end
    if (resp_id !== 2'd0) begin n_bad++; $display("FAIL rstx_resp_id: got %0d expected 0", resp_id); end
    tick();
  endtask

`ifdef FP_ARB_SUB_EN
  task automatic test_sub();
    bit ok;
    apply_reset();
    req_valid   = 4'b0001;
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'hBF800000;
    req_sub     = 4'b0001;
    resp_ready  = 1'b1;
    wait_for(1'b0, ok);
    tick();
    req_valid = '0;
    req_sub   = '0;
    wait_for(1'b1, ok);
    n_cmp++;
    if (!ok || resp_sum !== 32'h40400000) begin n_bad++; $display("FAIL sub_sum: got %h expected 40400000", resp_sum); end
    tick();
  endtask
`endif

  // Transaction-level model: at most one request in flight, whose result appears two cycles after
  // its grant and leaves on the first cycle resp_ready is high. Grants go round-robin from the last winner.
  task automatic test_random(input logic [N-1:0] mask, input int cycles);
    int lane_a[N];
    int lane_b[N];
    bit lane_s[N];
    int last, g, j, age;
    bit pending, exp_rv;
    logic [N-1:0] exp_ready;
    logic [31:0]  exp_sum;
    logic [1:0]   exp_id;
    apply_reset();
    last = N - 1;
    pending = 1'b0;
    age = 0;
    exp_sum = '0;
    exp_id = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = mask[i] & 1'($urandom_range(0, 1));
        lane_a[i] = int'($urandom_range(0, 2097152)) - 1048576;
        lane_b[i] = int'($urandom_range(0, 2097152)) - 1048576;
        lane_s[i] = 1'b0;
`ifdef FP_ARB_SUB_EN
        lane_s[i] = 1'($urandom_range(0, 1));
        req_sub[i] = lane_s[i];
`endif
        req_a[32*i +: 32] = to_float(lane_a[i]);
        req_b[32*i +: 32] = to_float(lane_b[i]);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = -1;
      if (!pending) begin
        for (int k = 1; k <= N; k++) begin
          j = (last + k) % N;
          if (g < 0 && req_valid[j[1:0]]) g = j;
        end
      end
      exp_ready = (g >= 0) ? (4'(1) << g) : 4'b0000;
      exp_rv = pending && (age >= 2);
      n_cmp += 3;
      if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_ready); end
      if (resp_valid !== exp_rv) begin n_bad++; $display("FAIL rnd_resp_valid cyc %0d: got %b expected %b", cyc, resp_valid, exp_rv); end
      if (busy !== pending) begin n_bad++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, pending); end
      if (exp_rv) begin
        n_cmp += 2;
        if (resp_sum !== exp_sum) begin n_bad++; $display("FAIL rnd_sum cyc %0d: got %h expected %h", cyc, resp_sum, exp_sum); end
        if (resp_id !== exp_id) begin n_bad++; $display("FAIL rnd_id cyc %0d: got %0d expected %0d", cyc, resp_id, exp_id); end
      end
      if (g >= 0) begin
        pending = 1'b1;
        age = 1;
        last = g;
        exp_id = 2'(g);
        exp_sum = to_float(lane_s[g] ? (lane_a[g] - lane_b[g]) : (lane_a[g] + lane_b[g]));
      end else if (pending) begin
        if (age >= 2 && resp_ready) pending = 1'b0;
        else if (age < 2) age++;
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_lanes();
    test_stall();
    test_reset_exec();
`ifdef FP_ARB_SUB_EN
    test_sub();
`endif
    test_random(4'b1010, 300);
    test_random(4'b1111, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
